// File: rtl/led_bank_arbiter.sv
// led_bank_arbiter: shares the 16-LED bank between NUM_REQ requesters and the
// slide-switch mirror. Fair round-robin with a minimum dwell time per grant.
// Optional macro LED_BANK_ARBITER_PRIORITY_EN: requester 0 becomes urgent and
// pre-empts any other owner; the pre-empted owner resumes when 0 releases.
`timescale 1ns/1ps

module led_bank_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_W       = 16,
    parameter int DWELL_CYCLES = 100000000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [DATA_W-1:0]            SW,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*DATA_W-1:0]    req_data,
    output logic [NUM_REQ-1:0]           gnt,
    output logic                         owner_valid,
    output logic [$clog2(NUM_REQ)-1:0]   owner_id,
    output logic [DATA_W-1:0]            LED
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(DWELL_CYCLES + 1);
    localparam logic [CNT_W-1:0] DWELL_MAX = CNT_W'(DWELL_CYCLES);
    localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NUM_REQ - 1);

    typedef enum logic {IDLE, OWN} state_t;

    state_t              state_q;
    logic [NUM_REQ-1:0]  gnt_q;
    logic                owner_valid_q;
    logic [ID_W-1:0]     owner_q;
    logic [ID_W-1:0]     ptr_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [DATA_W-1:0]   led_q;

    // Decision signals for the coming edge
    logic [NUM_REQ-1:0]  others;
    logic                others_any;
    logic                owner_req;
    logic                grant_en;
    logic                drop_en;
    logic                ptr_upd;
    logic [ID_W-1:0]     grant_id;

`ifdef LED_BANK_ARBITER_PRIORITY_EN
    logic                pre_set;
    logic                pre_v_q;
    logic [ID_W-1:0]     pre_id_q;
`endif

    // Next index with wrap-around at NUM_REQ
    function automatic logic [ID_W-1:0] inc_id(input logic [ID_W-1:0] id);
        return (id == LAST_ID) ? '0 : id + 1'b1;
    endfunction

    // First set bit of mask scanning upward from start, wrapping
    function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] mask,
                                                input logic [ID_W-1:0]    start);
        logic [ID_W-1:0] idx;
        logic [ID_W-1:0] pick;
        logic            found;
        idx   = start;
        pick  = start;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && mask[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
            idx = inc_id(idx);
        end
        return pick;
    endfunction

    // Arbitration decision: new grant, drop to idle, or keep the current owner
    always_comb begin
        others     = req & ~gnt_q;
        others_any = |others;
        owner_req  = req[owner_q];
        grant_en   = 1'b0;
        drop_en    = 1'b0;
        ptr_upd    = 1'b1;
        grant_id   = ptr_q;
`ifdef LED_BANK_ARBITER_PRIORITY_EN
        pre_set    = 1'b0;
`endif
        if (state_q == IDLE) begin
            if (|req) begin
                grant_en = 1'b1;
                grant_id = rr_pick(req, ptr_q);
            end
        end else begin
`ifdef LED_BANK_ARBITER_PRIORITY_EN
            if (owner_q != '0 && req[0]) begin
                // Urgent requester takes over; pointer untouched so the
                // victim is remembered and resumes first.
                grant_en = 1'b1;
                grant_id = '0;
                ptr_upd  = 1'b0;
                pre_set  = 1'b1;
            end else if (owner_q == '0) begin
                // Requester 0 is never rotated away, only released
                if (!owner_req) begin
                    if (pre_v_q && req[pre_id_q]) begin
                        grant_en = 1'b1;
                        grant_id = pre_id_q;
                    end else if (others_any) begin
                        grant_en = 1'b1;
                        grant_id = rr_pick(others, ptr_q);
                    end else begin
                        drop_en = 1'b1;
                    end
                end
            end else begin
`else
            begin
`endif
                if (!owner_req) begin
                    if (others_any) begin
                        grant_en = 1'b1;
                        grant_id = rr_pick(others, ptr_q);
                    end else begin
                        drop_en = 1'b1;
                    end
                end else if (cnt_q == DWELL_MAX && others_any) begin
                    grant_en = 1'b1;
                    grant_id = rr_pick(others, inc_id(owner_q));
                end
            end
        end
    end

    // FSM and registered outputs; LED follows SW in IDLE, the owner in OWN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            gnt_q         <= '0;
            owner_valid_q <= 1'b0;
            owner_q       <= '0;
            ptr_q         <= '0;
            cnt_q         <= '0;
            led_q         <= '0;
        end else if (grant_en) begin
            state_q       <= OWN;
            gnt_q         <= NUM_REQ'(1) << grant_id;
            owner_valid_q <= 1'b1;
            owner_q       <= grant_id;
            cnt_q         <= '0;
            led_q         <= req_data[grant_id*DATA_W +: DATA_W];
            if (ptr_upd) begin
                ptr_q <= inc_id(grant_id);
            end
        end else if (drop_en) begin
            state_q       <= IDLE;
            gnt_q         <= '0;
            owner_valid_q <= 1'b0;
            owner_q       <= '0;
            cnt_q         <= '0;
            led_q         <= req_data[owner_q*DATA_W +: DATA_W];
        end else if (state_q == OWN) begin
            led_q <= req_data[owner_q*DATA_W +: DATA_W];
            if (cnt_q != DWELL_MAX) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end else begin
            led_q <= SW;
        end
    end

`ifdef LED_BANK_ARBITER_PRIORITY_EN
    // Remembers which owner was pre-empted by requester 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_v_q  <= 1'b0;
            pre_id_q <= '0;
        end else if (grant_en || drop_en) begin
            pre_v_q <= pre_set;
            if (pre_set) begin
                pre_id_q <= owner_q;
            end
        end
    end
`endif

    assign gnt         = gnt_q;
    assign owner_valid = owner_valid_q;
    assign owner_id    = owner_q;
    assign LED         = led_q;

endmodule

// File: tb/tb_led_bank_arbiter.sv
// Self-checking bench for led_bank_arbiter (NUM_REQ=4, DWELL_CYCLES=4).
// Directed scenarios plus randomized traffic against a behavioural model.
`timescale 1ns/1ps

module tb_led_bank_arbiter;

    localparam int N     = 4;
    localparam int W     = 16;
    localparam int DWELL = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [W-1:0]     sw = 16'hA5A5;
    logic [N-1:0]     req = '0;
    logic [N*W-1:0]   req_data = '0;
    logic [N-1:0]     gnt;
    logic             owner_valid;
    logic [1:0]       owner_id;
    logic [W-1:0]     LED;

    int checks = 0;
    int passes = 0;

    // Model state: owner index (-1 = switches shown), cycles held, pointer
    int           m_owner;
    int           m_held;
    int           m_ptr;
    int           m_pre;
    logic [W-1:0] m_led;

    led_bank_arbiter #(.NUM_REQ(N), .DATA_W(W), .DWELL_CYCLES(DWELL)) dut (
        .clk(clk), .rst_n(rst_n), .SW(sw), .req(req), .req_data(req_data),
        .gnt(gnt), .owner_valid(owner_valid), .owner_id(owner_id), .LED(LED)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] data_of(input int i);
        return req_data[i*W +: W];
    endfunction

    function automatic int first_from(input logic [N-1:0] mask, input int start);
        for (int k = 0; k < N; k++) begin
            if (mask[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_gnt();
        logic [N-1:0] g;
        g = '0;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return g;
    endfunction

    function automatic logic [1:0] exp_id();
        return (m_owner < 0) ? 2'd0 : 2'(m_owner);
    endfunction

    task automatic model_reset();
        m_owner = -1; m_held = 0; m_ptr = 0; m_pre = -1; m_led = '0;
    endtask

    task automatic model_grant(input int x, input bit upd_ptr);
        m_owner = x;
        m_held  = 0;
        m_led   = data_of(x);
        m_pre   = -1;
        if (upd_ptr) m_ptr = (x + 1) % N;
    endtask

    task automatic model_idle();
        m_led   = data_of(m_owner);
        m_owner = -1;
        m_held  = 0;
        m_pre   = -1;
    endtask

    // One clock edge of the arbitration rules, using inputs present at the edge
    task automatic model_edge();
        logic [N-1:0] others;
        int           victim;
        if (m_owner < 0) begin
            m_led = sw;
            if (req != '0) model_grant(first_from(req, m_ptr), 1'b1);
            return;
        end
        others = req;
        others[m_owner] = 1'b0;
`ifdef LED_BANK_ARBITER_PRIORITY_EN
        if (m_owner != 0 && req[0]) begin
            victim = m_owner;
            model_grant(0, 1'b0);
            m_pre = victim;
            return;
        end
        if (m_owner == 0) begin
            if (!req[0]) begin
                if (m_pre >= 0 && req[m_pre]) model_grant(m_pre, 1'b1);
                else if (others != '0) model_grant(first_from(others, m_ptr), 1'b1);
                else model_idle();
            end else begin
                m_led = data_of(0);
                m_held++;
            end
            return;
        end
`else
        victim = -1;
`endif
        if (!req[m_owner]) begin
            if (others != '0) model_grant(first_from(others, m_ptr), 1'b1);
            else model_idle();
        end else if (m_held >= DWELL && others != '0) begin
            model_grant(first_from(others, (m_owner + 1) % N), 1'b1);
        end else begin
            m_led = data_of(m_owner);
            m_held++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req   = '0;
        @(posedge clk);
        #1;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        sw = 16'hA5A5;
        req = '0;
        req_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        #12;
        checks++;
        if (LED !== 16'h0000) $display("FAIL reset_led: got %h want 0000", LED);
        else passes++;
        checks++;
        if ({gnt, owner_valid, owner_id} !== 7'b0) $display("FAIL reset_gnt: gnt=%b valid=%b id=%0d want all zero", gnt, owner_valid, owner_id);
        else passes++;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        $display("reset release: LED=%h gnt=%b", LED, gnt);
        checks++;
        if (LED !== 16'hA5A5 || gnt !== 4'b0000) $display("FAIL reset_mirror: LED=%h gnt=%b want A5A5/0000", LED, gnt);
        else passes++;
    endtask

    task automatic test_single();
        req_data[2*W +: W] = 16'h00FF;
        req = 4'b0100;
        tick();
        $display("single grant: gnt=%b LED=%h id=%0d", gnt, LED, owner_id);
        checks++;
        if (gnt !== 4'b0100 || LED !== 16'h00FF || owner_id !== 2'd2 || owner_valid !== 1'b1)
            $display("FAIL single_grant: gnt=%b LED=%h id=%0d valid=%b want 0100/00FF/2/1", gnt, LED, owner_id, owner_valid);
        else passes++;
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++;
            if (gnt !== 4'b0100 || LED !== 16'h00FF) $display("FAIL single_hold cycle %0d: gnt=%b LED=%h want 0100/00FF", c, gnt, LED);
            else passes++;
        end
        req = 4'b0000;
        tick();
        $display("single drop: gnt=%b valid=%b", gnt, owner_valid);
        checks++;
        if (gnt !== 4'b0000 || owner_valid !== 1'b0 || owner_id !== 2'd0) $display("FAIL single_drop: gnt=%b valid=%b id=%0d want 0000/0/0", gnt, owner_valid, owner_id);
        else passes++;
        tick();
        checks++;
        if (LED !== 16'hA5A5) $display("FAIL single_sw_back: LED=%h want A5A5", LED);
        else passes++;
    endtask

    task automatic test_rotation();
        int exp_own [4] = '{0, 1, 3, 0};
        int o;
        apply_reset();
        req_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        req = 4'b1011;
        for (int c = 0; c < 20; c++) begin
            tick();
            o = exp_own[c / 5];
            $display("rotation cycle %0d: gnt=%b LED=%h", c, gnt, LED);
            checks++;
            if (gnt !== 4'(1 << o) || LED !== 16'(16'h1111 * (o + 1)) || owner_id !== 2'(o))
                $display("FAIL rot cycle %0d: gnt=%b LED=%h id=%0d want owner %0d", c, gnt, LED, owner_id, o);
            else passes++;
        end
    endtask

    task automatic test_early_release();
        apply_reset();
        req = 4'b1010;
        tick();
        tick();
        checks++;
        if (gnt !== 4'b0010) $display("FAIL early_owner1: gnt=%b want 0010", gnt);
        else passes++;
        req = 4'b1000;
        tick();
        $display("early release: gnt=%b id=%0d", gnt, owner_id);
        checks++;
        if (gnt !== 4'b1000 || owner_valid !== 1'b1 || owner_id !== 2'd3)
            $display("FAIL early_handover: gnt=%b valid=%b id=%0d want 1000/1/3", gnt, owner_valid, owner_id);
        else passes++;
    endtask

    task automatic test_async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        $display("async reset: gnt=%b LED=%h valid=%b", gnt, LED, owner_valid);
        checks++;
        if (gnt !== 4'b0000 || LED !== 16'h0000 || owner_valid !== 1'b0)
            $display("FAIL async_clear: gnt=%b LED=%h valid=%b want 0000/0000/0", gnt, LED, owner_valid);
        else passes++;
        model_reset();
        @(negedge clk);
        req = 4'b0110;
        rst_n = 1'b1;
        tick();
        checks++;
        if (gnt !== 4'b0010 || owner_id !== 2'd1) $display("FAIL async_first_grant: gnt=%b id=%0d want 0010/1", gnt, owner_id);
        else passes++;
    endtask

`ifdef LED_BANK_ARBITER_PRIORITY_EN
    task automatic test_priority();
        apply_reset();
        req = 4'b0100;
        tick();
        tick();
        req = 4'b0101;
        tick();
        $display("priority preempt: gnt=%b", gnt);
        checks++;
        if (gnt !== 4'b0001) $display("FAIL prio_preempt: gnt=%b want 0001", gnt);
        else passes++;
        for (int c = 0; c < 8; c++) tick();
        checks++;
        if (gnt !== 4'b0001) $display("FAIL prio_no_rotate: gnt=%b want 0001", gnt);
        else passes++;
        req = 4'b0100;
        tick();
        $display("priority resume: gnt=%b", gnt);
        checks++;
        if (gnt !== 4'b0100) $display("FAIL prio_resume: gnt=%b want 0100", gnt);
        else passes++;
    endtask
`endif

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            sw = W'($urandom);
            req_data = {$urandom, $urandom};
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 5) == 0) req[b] = ~req[b];
            end
            tick();
            $display("random cycle %0d: req=%b gnt=%b id=%0d LED=%h", c, req, gnt, owner_id, LED);
            checks++;
            if (gnt !== exp_gnt() || owner_valid !== (m_owner >= 0) || owner_id !== exp_id() || LED !== m_led)
                $display("FAIL random cycle %0d: gnt=%b valid=%b id=%0d LED=%h want %b/%b/%0d/%h",
                         c, gnt, owner_valid, owner_id, LED, exp_gnt(), (m_owner >= 0), exp_id(), m_led);
            else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_early_release();
        test_async_reset();
`ifdef LED_BANK_ARBITER_PRIORITY_EN
        test_priority();
`endif
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
